// File: rtl/laser_i2c_point_seq.sv
// Galvo point sequencer: turns each X/Y point into two I2C DAC writes fed byte-by-byte to the I2C byte engine.
// Optional macro LASER_I2C_SEQ_DEDUP_EN skips a channel whose value matches the last one written successfully.
module laser_i2c_point_seq #(
  parameter logic [6:0] DEV_ADDR = 7'h60,
  parameter int         DATA_W   = 12,
  parameter int         RETRIES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pt_x,
  input  logic [DATA_W-1:0] pt_y,
  input  logic              pt_valid,
  output logic              pt_ready,
  output logic [7:0]        din,
  output logic              start,
  output logic              stop,
  output logic              byte_req,
  input  logic              byte_done,
  input  logic              byte_nack,
  output logic              busy,
  output logic              err,
  output logic [7:0]        err_count
);

  localparam int TRY_W = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
  localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(RETRIES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_NEXT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;
  logic              r_ch;
  logic [1:0]        r_idx;
  logic [TRY_W-1:0]  r_try;
  logic              r_err;
  logic [7:0]        r_err_count;

  logic       w_accept;
  logic       w_done;
  logic       w_ack;
  logic       w_nacked;
  logic       w_retry;
  logic       w_abandon;
  logic       w_last_byte;
  logic       w_skip_x;
  logic       w_skip_y;
  logic [11:0] w_val;
  logic [7:0]  w_byte;

  assign w_accept    = (r_state == S_IDLE) && pt_valid;
  assign w_done      = (r_state == S_WAIT) && byte_done;
  assign w_ack       = w_done && !byte_nack;
  assign w_nacked    = w_done && byte_nack;
  assign w_retry     = w_nacked && (r_try != TRY_MAX);
  assign w_abandon   = w_nacked && (r_try == TRY_MAX);
  assign w_last_byte = (r_idx == 2'd3);

`ifdef LASER_I2C_SEQ_DEDUP_EN
  logic [DATA_W-1:0] r_last_x;
  logic [DATA_W-1:0] r_last_y;
  logic              r_last_x_vld;
  logic              r_last_y_vld;

  // X is judged against the incoming point at accept, Y against the latched point in NEXT.
  assign w_skip_x = r_last_x_vld && (pt_x == r_last_x);
  assign w_skip_y = r_last_y_vld && (r_y == r_last_y);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_x     <= '0;
      r_last_y     <= '0;
      r_last_x_vld <= 1'b0;
      r_last_y_vld <= 1'b0;
    end else begin
      if (w_ack && w_last_byte) begin
        if (!r_ch) begin
          r_last_x     <= r_x;
          r_last_x_vld <= 1'b1;
        end else begin
          r_last_y     <= r_y;
          r_last_y_vld <= 1'b1;
        end
      end
      if (w_abandon) begin
        if (!r_ch) r_last_x_vld <= 1'b0;
        else       r_last_y_vld <= 1'b0;
      end
    end
  end
`else
  assign w_skip_x = 1'b0;
  assign w_skip_y = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (pt_valid) w_state_next = w_skip_x ? S_NEXT : S_REQ;
      end
      S_REQ: w_state_next = S_WAIT;
      S_WAIT: begin
        if (byte_done) begin
          if (!byte_nack) w_state_next = w_last_byte ? S_NEXT : S_REQ;
          else            w_state_next = w_retry ? S_REQ : S_NEXT;
        end
      end
      S_NEXT: begin
        if (!r_ch) w_state_next = w_skip_y ? S_NEXT : S_REQ;
        else       w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_ch        <= 1'b0;
      r_idx       <= 2'd0;
      r_try       <= '0;
      r_err       <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_err <= w_abandon;
      if (w_abandon && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      if (w_accept) begin
        r_x   <= pt_x;
        r_y   <= pt_y;
        r_ch  <= 1'b0;
        r_idx <= 2'd0;
        r_try <= '0;
      end
      if (w_ack && !w_last_byte) r_idx <= r_idx + 2'd1;
      // A retry restarts the whole transaction so the engine emits a fresh START.
      if (w_retry) begin
        r_try <= r_try + 1'b1;
        r_idx <= 2'd0;
      end
      if ((r_state == S_NEXT) && !r_ch) begin
        r_ch  <= 1'b1;
        r_idx <= 2'd0;
        r_try <= '0;
      end
    end
  end

  assign w_val = r_ch ? 12'(r_y) : 12'(r_x);

  always_comb begin
    w_byte = 8'd0;
    case (r_idx)
      2'd0:    w_byte = {DEV_ADDR, 1'b0};
      2'd1:    w_byte = 8'h40 | {6'd0, r_ch, 1'b0};
      2'd2:    w_byte = {4'd0, w_val[11:8]};
      default: w_byte = w_val[7:0];
    endcase
  end

  // Byte fields only present while a request is outstanding, so they read zero out of reset.
  always_comb begin
    pt_ready  = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    byte_req  = (r_state == S_WAIT);
    din       = (r_state == S_WAIT) ? w_byte : 8'd0;
    start     = (r_state == S_WAIT) && (r_idx == 2'd0);
    stop      = (r_state == S_WAIT) && (r_idx == 2'd3);
    err       = r_err;
    err_count = r_err_count;
  end

endmodule

// File: tb/tb_laser_i2c_point_seq.sv
// Scoreboard bench for laser_i2c_point_seq: a point-level model queues expected bytes, an engine model answers requests.
module tb_laser_i2c_point_seq;

  localparam logic [6:0] DEV_ADDR = 7'h60;
  localparam int DATA_W  = 12;
  localparam int RETRIES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pt_x = '0;
  logic [11:0] pt_y = '0;
  logic        pt_valid = 1'b0;
  logic        pt_ready;
  logic [7:0]  din;
  logic        start;
  logic        stop;
  logic        byte_req;
  logic        byte_done = 1'b0;
  logic        byte_nack = 1'b0;
  logic        busy;
  logic        err;
  logic [7:0]  err_count;

  laser_i2c_point_seq #(.DEV_ADDR(DEV_ADDR), .DATA_W(DATA_W), .RETRIES(RETRIES)) dut (
    .clk(clk), .reset(reset), .pt_x(pt_x), .pt_y(pt_y), .pt_valid(pt_valid),
    .pt_ready(pt_ready), .din(din), .start(start), .stop(stop), .byte_req(byte_req),
    .byte_done(byte_done), .byte_nack(byte_nack), .busy(busy), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q[$];   // {din, start, stop}
  bit         resp_q[$];  // engine answer per byte: 1 = NACK
  int model_errs = 0;
  int seen_errs  = 0;
  int hold_level = -1;
  logic [11:0] last_v [2];
  bit          last_ok [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] chan_byte(input int ch, input logic [11:0] v, input int idx);
    case (idx)
      0:       return {DEV_ADDR, 1'b0};
      1:       return 8'h40 + 8'(2 * ch);
      2:       return {4'h0, v[11:8]};
      default: return v[7:0];
    endcase
  endfunction

  function automatic bit chan_skipped(input int ch, input logic [11:0] v);
`ifdef LASER_I2C_SEQ_DEDUP_EN
    return last_ok[ch] && (last_v[ch] == v);
`else
    return 1'b0;
`endif
  endfunction

  // nn attempts are NACKed at byte kk; the transaction is abandoned when all RETRIES+1 attempts fail.
  function automatic void model_channel(input int ch, input logic [11:0] v, input int nn, input int kk);
    int last;
    if (chan_skipped(ch, v)) return;
    for (int a = 0; a <= RETRIES; a++) begin
      last = (a < nn) ? kk : 3;
      for (int i = 0; i <= last; i++) begin
        exp_q.push_back({chan_byte(ch, v, i), i == 0, i == 3});
        resp_q.push_back((a < nn) && (i == last));
      end
      if (a >= nn) begin
        last_v[ch]  = v;
        last_ok[ch] = 1'b1;
        return;
      end
    end
    model_errs++;
    last_ok[ch] = 1'b0;
  endfunction

  task automatic send_point(input logic [11:0] x, input logic [11:0] y, input int nx, input int kx,
                            input int ny, input int ky, input bit hold);
    int guard = 0;
    bit x_sends;
    pt_x = x;
    pt_y = y;
    pt_valid = 1'b1;
    while (!pt_ready) begin
      if (guard > 3000) begin
        check("accept_timeout", 32'(pt_ready), 32'd1);
        pt_valid = 1'b0;
        return;
      end
      guard++;
      @(negedge clk);
    end
    x_sends = !chan_skipped(0, x);
    model_channel(0, x, nx, kx);
    model_channel(1, y, ny, ky);
    @(posedge clk);
    @(negedge clk);
    pt_x = 12'($urandom);
    pt_y = 12'($urandom);
    if (!hold) pt_valid = 1'b0;
    check("ready_low_after_accept", 32'(pt_ready), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("no_req_first_cycle", 32'(byte_req), 32'd0);
    @(negedge clk);
    if (x_sends) check("first_req_latency", 32'(byte_req), 32'd1);
    else         check("ready_low_second_cycle", 32'(pt_ready), 32'd0);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("drain_done", 32'(g < 5000), 32'd1);
    check("ready_after_point", 32'(pt_ready), 32'd1);
  endtask

  // Byte engine model: random response delay, spurious NACK while busy, answers from resp_q.
  initial begin
    int  cnt = 0;
    bit  pending = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending = 1'b0;
        byte_done = 1'b0;
        byte_nack = 1'b0;
      end else if (byte_done) begin
        byte_done = 1'b0;
        byte_nack = 1'b0;
      end else begin
        if (!pending && byte_req && (exp_q.size() != hold_level)) begin
          pending = 1'b1;
          cnt = $urandom_range(0, 2);
        end
        if (pending) begin
          if (cnt == 0) begin
            byte_done = 1'b1;
            byte_nack = 1'b0;
            if (resp_q.size() > 0) byte_nack = resp_q.pop_front();
            pending = 1'b0;
          end else begin
            cnt--;
            byte_nack = 1'($urandom_range(0, 1));
          end
        end
      end
    end
  end

  // Monitor: every completed byte is compared to the scoreboard head.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (byte_done && !reset) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_byte: got %0h, required no byte", {din, start, stop});
        end else begin
          e = exp_q.pop_front();
          check("byte", 32'({din, start, stop}), 32'(e));
        end
        check("req_held_at_done", 32'(byte_req), 32'd1);
      end
      if (err) seen_errs++;
    end
  end

  initial begin
    int g;
    logic [11:0] rx, ry, prev_x, prev_y;
    int r, nx, kx, ny, ky;
    last_ok[0] = 1'b0;
    last_ok[1] = 1'b0;
    last_v[0] = '0;
    last_v[1] = '0;

    repeat (3) @(negedge clk);
    check("rst_pt_ready", 32'(pt_ready), 32'd1);
    check("rst_byte_req", 32'(byte_req), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_stop", 32'(stop), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    send_point(12'hABC, 12'h123, 0, 0, 0, 0, 1'b0);
    drain();

    // Back-to-back with pt_valid held high throughout.
    send_point(12'h111, 12'h222, 0, 0, 0, 0, 1'b1);
    send_point(12'h333, 12'h444, 0, 0, 0, 0, 1'b1);
    send_point(12'h555, 12'h666, 0, 0, 0, 0, 1'b0);
    drain();

    send_point(12'h5A5, 12'h6B6, 1, 1, 0, 0, 1'b0);
    drain();
    check("single_nack_no_err", 32'(err_count), 32'(model_errs));
    check("single_nack_err_seen", 32'(seen_errs), 32'(model_errs));

    send_point(12'h7C7, 12'h8D8, 3, 0, 0, 0, 1'b0);
    drain();
    check("persistent_nack_count", 32'(err_count), 32'(model_errs));
    check("persistent_nack_pulses", 32'(seen_errs), 32'(model_errs));

    // Reset while the engine is holding X idx2.
    hold_level = 6;
    send_point(12'h3C7, 12'h4D8, 0, 0, 0, 0, 1'b0);
    g = 0;
    while (!(byte_req && exp_q.size() == 6) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("reached_idx2", 32'(g < 200), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("midrst_byte_req", 32'(byte_req), 32'd0);
    check("midrst_din", 32'(din), 32'd0);
    check("midrst_start", 32'(start), 32'd0);
    check("midrst_stop", 32'(stop), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pt_ready", 32'(pt_ready), 32'd1);
    check("midrst_err_count", 32'(err_count), 32'd0);
    exp_q.delete();
    resp_q.delete();
    last_ok[0] = 1'b0;
    last_ok[1] = 1'b0;
    model_errs = 0;
    seen_errs = 0;
    hold_level = -1;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    send_point(12'h7E1, 12'h0F2, 0, 0, 0, 0, 1'b0);
    drain();

    send_point(12'd100, 12'd200, 0, 0, 0, 0, 1'b0);
    drain();
    send_point(12'd100, 12'd300, 0, 0, 0, 0, 1'b0);
    drain();
    send_point(12'd100, 12'd300, 0, 0, 0, 0, 1'b0);
    drain();

    prev_x = 12'd100;
    prev_y = 12'd300;
    for (int n = 0; n < 40; n++) begin
      rx = ($urandom_range(0, 9) < 3) ? prev_x : 12'($urandom);
      ry = ($urandom_range(0, 9) < 3) ? prev_y : 12'($urandom);
      r = $urandom_range(0, 7);
      nx = (r < 5) ? 0 : r - 4;
      kx = $urandom_range(0, 3);
      r = $urandom_range(0, 7);
      ny = (r < 5) ? 0 : r - 4;
      ky = $urandom_range(0, 3);
      send_point(rx, ry, nx, kx, ny, ky, (n != 39) && ($urandom_range(0, 1) == 1));
      prev_x = rx;
      prev_y = ry;
    end
    drain();
    check("final_err_count", 32'(err_count), 32'((model_errs > 255) ? 255 : model_errs));
    check("final_err_pulses", 32'(seen_errs), 32'(model_errs));
    check("final_busy", 32'(busy), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
